// File: rtl/serial_addsub_if.sv
// Start/done handshake bundle for the bit-serial adder/subtractor.
//   master : controlling sequencer (drives start/sub/a/b, observes status/result)
//   slave  : serial_addsub datapath
// Signals:
//   start     request, sampled only while busy=0
//   sub       0 = a+b, 1 = a-b (sampled with start)
//   a, b      operands (sampled with start)
//   busy      high while a computation is in progress
//   done      one-cycle pulse when result/flags are valid
//   result    sum/difference, held until the next accepted op completes
//   carry_out final carry (for subtract: 1 = no borrow)
//   overflow  signed overflow of the last op
interface serial_addsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor.
// One full-adder cell is reused over WIDTH cycles, LSB first, with a
// registered carry. Subtraction is a + ~b + 1: B is inverted at accept and
// the carry flop is preloaded with 1.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts any operation in flight)
//   bus    serial_addsub_if slave modport (start/sub/a/b in; busy/done/
//          result/carry_out/overflow out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; result/flags hold the last completed op
// RUN   | processing one bit per clock, cnt = index of bit being added
module serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_addsub_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] areg, areg_nxt;
  logic [WIDTH-1:0] breg, breg_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] result_q, result_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             carry, carry_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic             cout_q, cout_nxt;
  logic             ovf_q, ovf_nxt;

  // Single full-adder cell on the current LSBs.
  logic fa_s;
  logic fa_c;

  assign fa_s = areg[0] ^ breg[0] ^ carry;
  assign fa_c = (areg[0] & breg[0]) | (areg[0] & carry) | (breg[0] & carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      areg     <= '0;
      breg     <= '0;
      acc      <= '0;
      result_q <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      areg     <= areg_nxt;
      breg     <= breg_nxt;
      acc      <= acc_nxt;
      result_q <= result_nxt;
      cnt      <= cnt_nxt;
      carry    <= carry_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      cout_q   <= cout_nxt;
      ovf_q    <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    areg_nxt   = areg;
    breg_nxt   = breg;
    acc_nxt    = acc;
    result_nxt = result_q;
    cnt_nxt    = cnt;
    carry_nxt  = carry;
    busy_nxt   = busy_q;
    done_nxt   = 1'b0;
    cout_nxt   = cout_q;
    ovf_nxt    = ovf_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          areg_nxt  = bus.a;
          breg_nxt  = bus.sub ? ~bus.b : bus.b;
          carry_nxt = bus.sub;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end

      RUN: begin
        areg_nxt  = areg >> 1;
        breg_nxt  = breg >> 1;
        acc_nxt   = {fa_s, acc[WIDTH-1:1]};
        carry_nxt = fa_c;
        cnt_nxt   = cnt + CNT_W'(1);
        if (cnt == LAST_BIT) begin
          result_nxt = {fa_s, acc[WIDTH-1:1]};
          cout_nxt   = fa_c;
          // carry holds the carry into the MSB on this edge
          ovf_nxt    = fa_c ^ carry;
          busy_nxt   = 1'b0;
          done_nxt   = 1'b1;
          state_nxt  = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  serial_addsub_if #(.WIDTH(16)) bus16 ();
  serial_addsub_if #(.WIDTH(4))  bus4 ();

  serial_addsub #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  serial_addsub #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge. Presents an op, lets the next
  // edge accept it, then waits (bounded) for done.
  task automatic do_op16(input logic s, input logic [15:0] av, input logic [15:0] bv,
                         output int lat, output int bcyc);
    bus16.start = 1'b1;
    bus16.sub   = s;
    bus16.a     = av;
    bus16.b     = bv;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    bcyc = (bus16.busy === 1'b1) ? 1 : 0;
    lat  = 0;
    while (bus16.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus16.busy === 1'b1) bcyc++;
    end
  endtask

  task automatic do_op4(input logic s, input logic [3:0] av, input logic [3:0] bv,
                        output int lat);
    bus4.start = 1'b1;
    bus4.sub   = s;
    bus4.a     = av;
    bus4.b     = bv;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    lat = 0;
    while (bus4.done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({bus16.busy, bus16.done, bus16.result, bus16.carry_out, bus16.overflow} !== 20'h0) begin
      fails++;
      $display("FAIL reset16: busy=%b done=%b result=%h co=%b ov=%b, required all 0",
               bus16.busy, bus16.done, bus16.result, bus16.carry_out, bus16.overflow);
    end
    tests++;
    if ({bus4.busy, bus4.done, bus4.result, bus4.carry_out, bus4.overflow} !== 8'h0) begin
      fails++;
      $display("FAIL reset4: busy=%b done=%b result=%h co=%b ov=%b, required all 0",
               bus4.busy, bus4.done, bus4.result, bus4.carry_out, bus4.overflow);
    end
  endtask

  task automatic test_add();
    int lat, bc;
    do_op16(1'b0, 16'h0003, 16'h0004, lat, bc);
    tests++;
    if (lat !== 16) begin fails++; $display("FAIL add_latency: got %0d, required 16", lat); end
    tests++;
    if (bc !== 16) begin fails++; $display("FAIL add_busy_cycles: got %0d, required 16", bc); end
    tests++;
    if ({bus16.result, bus16.carry_out, bus16.overflow} !== {16'h0007, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL add_3_4: result=%h co=%b ov=%b, required 0007 0 0",
               bus16.result, bus16.carry_out, bus16.overflow);
    end
    @(posedge clk); #1;
    tests++;
    if (bus16.done !== 1'b0 || bus16.result !== 16'h0007) begin
      fails++;
      $display("FAIL done_pulse_hold: done=%b result=%h, required 0 0007", bus16.done, bus16.result);
    end
  endtask

  task automatic test_sub();
    int lat, bc;
    do_op16(1'b1, 16'h0005, 16'h0007, lat, bc);
    tests++;
    if (lat !== 16 || {bus16.result, bus16.carry_out, bus16.overflow} !== {16'hFFFE, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL sub_5_7: lat=%0d result=%h co=%b ov=%b, required 16 FFFE 0 0",
               lat, bus16.result, bus16.carry_out, bus16.overflow);
    end
    @(posedge clk); #1;
    do_op16(1'b1, 16'h0007, 16'h0005, lat, bc);
    tests++;
    if (lat !== 16 || {bus16.result, bus16.carry_out, bus16.overflow} !== {16'h0002, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL sub_7_5: lat=%0d result=%h co=%b ov=%b, required 16 0002 1 0",
               lat, bus16.result, bus16.carry_out, bus16.overflow);
    end
  endtask

  task automatic test_boundaries();
    int lat, bc;
    @(posedge clk); #1;
    do_op16(1'b0, 16'h7FFF, 16'h0001, lat, bc);
    tests++;
    if ({bus16.result, bus16.carry_out, bus16.overflow} !== {16'h8000, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL add_7fff_1: result=%h co=%b ov=%b, required 8000 0 1",
               bus16.result, bus16.carry_out, bus16.overflow);
    end
    @(posedge clk); #1;
    do_op16(1'b0, 16'hFFFF, 16'h0001, lat, bc);
    tests++;
    if ({bus16.result, bus16.carry_out, bus16.overflow} !== {16'h0000, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL add_ffff_1: result=%h co=%b ov=%b, required 0000 1 0",
               bus16.result, bus16.carry_out, bus16.overflow);
    end
    @(posedge clk); #1;
    do_op16(1'b1, 16'h8000, 16'h0001, lat, bc);
    tests++;
    if ({bus16.result, bus16.carry_out, bus16.overflow} !== {16'h7FFF, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL sub_8000_1: result=%h co=%b ov=%b, required 7FFF 1 1",
               bus16.result, bus16.carry_out, bus16.overflow);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    @(posedge clk); #1;
    bus16.start = 1'b1;
    bus16.sub   = 1'b0;
    bus16.a     = 16'h1234;
    bus16.b     = 16'h0101;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    lat = 0;
    while (bus16.done !== 1'b1 && lat < 40) begin
      if (lat == 3) begin
        bus16.start = 1'b1;
        bus16.a     = 16'h1111;
        bus16.b     = 16'h2222;
        bus16.sub   = 1'b1;
      end else if (lat == 4) begin
        bus16.start = 1'b0;
        bus16.a     = 16'hFFFF;
        bus16.b     = 16'hAAAA;
      end
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (lat !== 16 || {bus16.result, bus16.carry_out, bus16.overflow} !== {16'h1335, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL ignore_start_busy: lat=%0d result=%h co=%b ov=%b, required 16 1335 0 0",
               lat, bus16.result, bus16.carry_out, bus16.overflow);
    end
    // start presented in the done cycle
    do_op16(1'b1, 16'h0100, 16'h0001, lat, bc);
    tests++;
    if (lat !== 16 || bc !== 16) begin
      fails++;
      $display("FAIL start_in_done_latency: lat=%0d busy=%0d, required 16 16", lat, bc);
    end
    tests++;
    if ({bus16.result, bus16.carry_out, bus16.overflow} !== {16'h00FF, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL start_in_done_result: result=%h co=%b ov=%b, required 00FF 1 0",
               bus16.result, bus16.carry_out, bus16.overflow);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc, nd;
    @(posedge clk); #1;
    bus16.start = 1'b1;
    bus16.sub   = 1'b0;
    bus16.a     = 16'h0F0F;
    bus16.b     = 16'h00FF;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus16.busy, bus16.done, bus16.result, bus16.carry_out, bus16.overflow} !== 20'h0) begin
      fails++;
      $display("FAIL abort_outputs: busy=%b done=%b result=%h co=%b ov=%b, required all 0",
               bus16.busy, bus16.done, bus16.result, bus16.carry_out, bus16.overflow);
    end
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    nd = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus16.done === 1'b1 || bus16.busy === 1'b1) nd++;
    end
    tests++;
    if (nd !== 0) begin
      fails++;
      $display("FAIL abort_no_done: busy/done seen %0d cycles, required 0", nd);
    end
    do_op16(1'b1, 16'h0010, 16'h0001, lat, bc);
    tests++;
    if (lat !== 16 || {bus16.result, bus16.carry_out, bus16.overflow} !== {16'h000F, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL post_reset_sub: lat=%0d result=%h co=%b ov=%b, required 16 000F 1 0",
               lat, bus16.result, bus16.carry_out, bus16.overflow);
    end
  endtask

  task automatic test_exhaustive4();
    int lat;
    logic [3:0] bb;
    logic [4:0] sum;
    logic [3:0] low;
    logic [5:0] exp_v;
    for (int s = 0; s < 2; s++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          bb    = (s != 0) ? ~4'(bi) : 4'(bi);
          sum   = 5'(ai) + 5'(bb) + 5'(s);
          low   = 4'((ai & 7) + (bb & 4'd7) + s);
          exp_v = {sum[3:0], sum[4], sum[4] ^ low[3]};
          @(posedge clk); #1;
          do_op4(s[0], 4'(ai), 4'(bi), lat);
          tests++;
          if (lat !== 4 || {bus4.result, bus4.carry_out, bus4.overflow} !== exp_v) begin
            fails++;
            $display("FAIL exh4 s=%0d a=%0d b=%0d: lat=%0d result=%h co=%b ov=%b, required 4 %h %b %b",
                     s, ai, bi, lat, bus4.result, bus4.carry_out, bus4.overflow,
                     exp_v[5:2], exp_v[1], exp_v[0]);
          end
        end
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus16.start = 1'b0; bus16.sub = 1'b0; bus16.a = '0; bus16.b = '0;
    bus4.start  = 1'b0; bus4.sub  = 1'b0; bus4.a  = '0; bus4.b  = '0;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_sub();
    test_boundaries();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial two's-complement adder/subtractor for the Hack datapath.
- Reuses a single full-adder cell over WIDTH clock cycles. A registered carry flop runs LSB-first.
- Sits beside the ALU as a low-area arithmetic unit. Provides subtraction (A - B), the inverse of plain addition, by inverting B and injecting carry-in = 1.
- Start/done handshake to a controlling sequencer.

Parameters:
WIDTH, 16, operand/result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
sub  input  1  operation select, sampled with start: 0 = A+B, 1 = A-B
a  input  WIDTH  operand A, sampled with start
b  input  WIDTH  operand B, sampled with start
busy  output  1  high while computing
done  output  1  one-cycle pulse: result/flags valid
result  output  WIDTH  sum/difference, held until next accepted start completes
carry_out  output  1  final carry (sub=1: 1 = no borrow, i.e. a >= b unsigned)
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
Reset
- rst_n=0 asynchronously clears all registers: state=IDLE; busy, done, result, carry_out, overflow, bit counter, operand shift registers, carry flop all 0.
- Reset asserted mid-operation aborts the operation; no done pulse follows.

States
- IDLE -> RUN on a clock edge with start=1.
- RUN -> IDLE after the WIDTH-th bit is processed.

Accept (IDLE, start=1)
- areg <= a.
- breg <= sub ? ~b : b.
- carry <= sub.
- cnt <= 0.
- busy <= 1.
- result, carry_out, overflow keep their previous values until done.

RUN, each edge
- s = areg[0] ^ breg[0] ^ carry.
- c = majority(areg[0], breg[0], carry).
- areg, breg shift right by 1.
- Accumulator shifts right with s entering at MSB.
- carry <= c.
- cnt <= cnt + 1.
- On the edge where cnt == WIDTH-1 (last bit):
  - result <= {s, accumulator[WIDTH-1:1]}.
  - carry_out <= c.
  - overflow <= c ^ (carry entering MSB), i.e. the carry register value at that edge.
  - busy <= 0, done <= 1, state <= IDLE.

Timing and handshake
- done is high exactly one cycle, then 0.
- Latency: start sampled at edge N -> done high in the cycle after edge N+WIDTH. busy is high for exactly WIDTH cycles.
- start while busy=1 is ignored; no queuing. Operand/sub changes during RUN have no effect.
- start=1 in the same cycle done=1: accepted (state already IDLE). Back-to-back throughput is one op per WIDTH+1 cycles.

Arithmetic
- Modulo 2^WIDTH; no saturation.
- cnt width is clog2(WIDTH); no wrap within an operation.

Test Plan:
1. Add, sub=0, a=16'h0003, b=16'h0004 -> done 16 cycles after accepting edge; result=16'h0007, carry_out=0, overflow=0; busy high exactly 16 cycles.
2. Subtract, sub=1, a=16'h0005, b=16'h0007 -> result=16'hFFFE, carry_out=0 (borrow), overflow=0. Then a=16'h0007, b=16'h0005 -> result=16'h0002, carry_out=1.
3. Boundaries:
   - sub=0, a=16'h7FFF, b=16'h0001 -> result=16'h8000, overflow=1, carry_out=0.
   - sub=0, a=16'hFFFF, b=16'h0001 -> result=16'h0000, carry_out=1, overflow=0.
   - sub=1, a=16'h8000, b=16'h0001 -> result=16'h7FFF, overflow=1.
4. Handshake: during RUN pulse start with a=16'h1111 and change a/b/sub -> ignored, first result unchanged. Assert start in the done cycle -> second op accepted; its done arrives 16 cycles later.
5. Reset: drop rst_n asynchronously (mid-cycle) at bit 8 of an operation -> all outputs 0 immediately, no done pulse. After release, a fresh start (a=16'h0010, b=16'h0001, sub=1) -> result=16'h000F.
6. Exhaustive: WIDTH=4 instance, all 16x16 operand pairs x sub in {0,1} -> result, carry_out, overflow match the reference model.
